alu16_mc: RTL and testbench

Multi-cycle 16-bit arithmetic unit for the CPU's 16-bit instructions: ADD HL,rr; ADD SP,e8 / LD HL,SP+e8; INC rr; DEC rr. It sits beside the 8-bit ALU and shares the `flags_t` Z/N/H/C layout from `alu_pkg`. Each operation runs over a narrow adder slice for `16/SLICE_W` cycles, so the area/latency trade-off is set at elaboration time. Input and output use valid/ready handshakes, and the block holds one operation at a time.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_slice_add.sv | 27 ++
 rtl/alu16_mc.sv | 125 ++++++++++++
 tb/tb_alu16_mc.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: the F-register flag layout plus the 16-bit ALU op and FSM encodings.
package alu_pkg;

   typedef struct packed {
      logic z;
      logic n;
      logic h;
      logic c;
   } flags_t;

   typedef enum logic [1:0] {
      ADD16 = 2'd0,
      ADDSP = 2'd1,
      INC16 = 2'd2,
      DEC16 = 2'd3
   } alu16_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } alu16_state_t;

   // Second adder operand; unknown ops add zero so the result is A unchanged.
   function automatic logic [15:0] alu16_eff_b(alu16_op_t op, logic [15:0] b);
      case (op)
         ADD16:   return b;
         ADDSP:   return {{8{b[7]}}, b[7:0]};
         INC16:   return 16'h0001;
         DEC16:   return 16'hFFFF;
         default: return 16'h0000;
      endcase
   endfunction

endpackage

// File: rtl/alu_slice_add.sv
// Combinational W-bit slice adder built from nibble adders, exposing each nibble carry-out.
module alu_slice_add #(
   parameter int W = 8
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic           cin,
   output logic [W-1:0]   sum,
   output logic [W/4-1:0] ncarry
);

   always_comb begin
      logic       c;
      logic [4:0] t;
      c      = cin;
      t      = '0;
      sum    = '0;
      ncarry = '0;
      for (int j = 0; j < W / 4; j++) begin
         t            = {1'b0, a[j*4 +: 4]} + {1'b0, b[j*4 +: 4]} + {4'b0000, c};
         sum[j*4 +: 4] = t[3:0];
         c            = t[4];
         ncarry[j]    = c;
      end
   end

endmodule

// File: rtl/alu16_mc.sv
// Multi-cycle 16-bit ALU: walks a SLICE_W-wide adder across the operands, one slice per cycle,
// collecting nibble carries for the H/C flags; valid/ready on both sides, one op in flight.
module alu16_mc
   import alu_pkg::*;
#(
   parameter int SLICE_W = 8,
   parameter int NSLICE  = 16 / SLICE_W
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      in_valid,
   output logic      in_ready,
   input  alu16_op_t op,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  flags_t    flags_in,
   output logic      out_valid,
   input  logic      out_ready,
   output logic [15:0] res,
   output flags_t    flags_out
);

   localparam int CW  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int NPS = SLICE_W / 4;

   alu16_state_t        state;
   logic [CW-1:0]       cnt;
   logic [15:0]         a_r;
   logic [15:0]         b_r;
   alu16_op_t           op_r;
   flags_t              fin_r;
   logic                carry;
   logic [3:0]          nib_c;
   logic [15:0]         res_r;
   flags_t              flags_r;

   int                  idx;
   logic [SLICE_W-1:0]  a_sl;
   logic [SLICE_W-1:0]  b_sl;
   logic [SLICE_W-1:0]  sum_sl;
   logic [NPS-1:0]      ncarry;
   logic [3:0]          nib_next;
   logic                last;

   function automatic flags_t flags_calc(alu16_op_t o, flags_t f, logic [3:0] nib);
      flags_t r;
      case (o)
         ADD16:   r = '{z: f.z,  n: 1'b0, h: nib[2], c: nib[3]};
         ADDSP:   r = '{z: 1'b0, n: 1'b0, h: nib[0], c: nib[1]};
         default: r = f;
      endcase
      return r;
   endfunction

   assign idx  = int'(cnt) * SLICE_W;
   assign last = (int'(cnt) == NSLICE - 1);

   always_comb begin
      a_sl = a_r[idx +: SLICE_W];
      b_sl = b_r[idx +: SLICE_W];
   end

   alu_slice_add #(.W(SLICE_W)) u_slice (
      .a      (a_sl),
      .b      (b_sl),
      .cin    (carry),
      .sum    (sum_sl),
      .ncarry (ncarry)
   );

   // Nibble carries of this slice land at their global nibble position (bits 3/7/11/15).
   always_comb begin
      nib_next = nib_c;
      for (int j = 0; j < NPS; j++) begin
         nib_next[int'(cnt) * NPS + j] = ncarry[j];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         carry   <= 1'b0;
         nib_c   <= '0;
         res_r   <= '0;
         flags_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_r   <= A;
                  b_r   <= alu16_eff_b(op, B);
                  op_r  <= op;
                  fin_r <= flags_in;
                  cnt   <= '0;
                  carry <= 1'b0;
                  nib_c <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               res_r[idx +: SLICE_W] <= sum_sl;
               carry                 <= ncarry[NPS-1];
               nib_c                 <= nib_next;
               if (last) begin
                  flags_r <= flags_calc(op_r, fin_r, nib_next);
                  state   <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign res       = res_r;
   assign flags_out = flags_r;

endmodule

// File: tb/tb_alu16_mc.sv
// Drives three alu16_mc instances (SLICE_W 4, 8, 16) in lockstep from a vector table and checks
// each against a queue of bench-computed expectations.
module tb_alu16_mc;
   import alu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic                in_valid;
   logic                out_ready;
   alu16_op_t           op;
   logic [15:0]         A;
   logic [15:0]         B;
   flags_t              flags_in;
   logic [2:0]          in_ready;
   logic [2:0]          out_valid;
   logic [2:0][15:0]    res_v;
   flags_t [2:0]        fo_v;

   alu16_mc #(.SLICE_W(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .op(op), .A(A), .B(B),
      .flags_in(flags_in), .out_valid(out_valid[0]), .out_ready(out_ready), .res(res_v[0]),
      .flags_out(fo_v[0]));
   alu16_mc #(.SLICE_W(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .op(op), .A(A), .B(B),
      .flags_in(flags_in), .out_valid(out_valid[1]), .out_ready(out_ready), .res(res_v[1]),
      .flags_out(fo_v[1]));
   alu16_mc #(.SLICE_W(16)) u16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .op(op), .A(A), .B(B),
      .flags_in(flags_in), .out_valid(out_valid[2]), .out_ready(out_ready), .res(res_v[2]),
      .flags_out(fo_v[2]));

   typedef struct {
      alu16_op_t   op;
      logic [15:0] a;
      logic [15:0] b;
      flags_t      f;
      logic [15:0] eres;
      flags_t      ef;
      bit          bp;
   } vec_t;

   typedef struct {
      logic [15:0] eres;
      flags_t      ef;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   sw[3]    = '{4, 8, 16};
   int   ns[3]    = '{4, 2, 1};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s sw%0d got=%h want=%h", nm, sw[i], act, exp);
      end
   endtask

   task automatic run_op(input vec_t v, input int n);
      logic [2:0]          seen;
      int                  cyc;
      exp_t                e;
      logic [2:0][15:0]    held_r;
      flags_t [2:0]        held_f;
      seen      = '0;
      held_r    = '0;
      held_f    = '0;
      e.eres    = '0;
      e.ef      = '0;
      out_ready = !v.bp;
      op        = v.op;
      A         = v.a;
      B         = v.b;
      flags_in  = v.f;
      in_valid  = 1'b1;
      exp_q.push_back('{eres: v.eres, ef: v.ef});
      tick();
      in_valid = 1'b0;
      op       = alu16_op_t'(2'($urandom));
      A        = 16'($urandom);
      B        = 16'($urandom);
      flags_in = flags_t'(4'($urandom));
      cyc      = 0;
      while (seen != 3'b111 && cyc < 12) begin
         tick();
         cyc++;
         for (int i = 0; i < 3; i++) begin
            if (!seen[i] && out_valid[i]) begin
               if (seen == 3'b000) e = exp_q.pop_front();
               seen[i] = 1'b1;
               chk($sformatf("v%0d_lat", n), i, cyc, ns[i]);
               chk($sformatf("v%0d_res", n), i, res_v[i], e.eres);
               chk($sformatf("v%0d_flags", n), i, fo_v[i], e.ef);
               chk($sformatf("v%0d_rdy_vs_vld", n), i, in_ready[i], 0);
               held_r[i] = res_v[i];
               held_f[i] = fo_v[i];
            end
         end
      end
      if (seen != 3'b111) begin
         chk($sformatf("v%0d_timeout", n), 0, seen, 3'b111);
         if (seen == 3'b000 && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (v.bp) begin
         for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            tick();
            for (int i = 0; i < 3; i++) begin
               chk($sformatf("v%0d_bp_res", n), i, res_v[i], held_r[i]);
               chk($sformatf("v%0d_bp_flags", n), i, fo_v[i], held_f[i]);
               chk($sformatf("v%0d_bp_vld_rdy", n), i, {out_valid[i], in_ready[i]}, 2'b10);
            end
         end
         in_valid  = 1'b1;
         out_ready = 1'b1;
         tick();
         in_valid = 1'b0;
         for (int i = 0; i < 3; i++)
            chk($sformatf("v%0d_release_idle", n), i, {out_valid[i], in_ready[i]}, 2'b01);
      end else begin
         tick();
         for (int i = 0; i < 3; i++)
            chk($sformatf("v%0d_idle", n), i, {out_valid[i], in_ready[i]}, 2'b01);
      end
   endtask

   vec_t vecs[13];

   initial begin
      //                op     a         b         f        eres      ef       bp
      vecs[0]  = '{ADD16, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010, 1'b0};
      vecs[1]  = '{ADD16, 16'h8000, 16'h8000, 4'b0000, 16'h0000, 4'b0001, 1'b0};
      vecs[2]  = '{ADDSP, 16'hFFF8, 16'h0008, 4'b1111, 16'h0000, 4'b0011, 1'b0};
      vecs[3]  = '{ADDSP, 16'h0005, 16'h00FF, 4'b1000, 16'h0004, 4'b0011, 1'b0};
      vecs[4]  = '{DEC16, 16'h0000, 16'h1234, 4'b1010, 16'hFFFF, 4'b1010, 1'b0};
      vecs[5]  = '{INC16, 16'hFFFF, 16'hABCD, 4'b0101, 16'h0000, 4'b0101, 1'b0};
      vecs[6]  = '{ADD16, 16'h1234, 16'h4321, 4'b0100, 16'h5555, 4'b0000, 1'b1};
      vecs[7]  = '{ADD16, 16'hF800, 16'h0800, 4'b1110, 16'h0000, 4'b1011, 1'b0};
      vecs[8]  = '{ADDSP, 16'h1000, 16'h5580, 4'b1111, 16'h0F80, 4'b0000, 1'b0};
      vecs[9]  = '{INC16, 16'h00FF, 16'h0000, 4'b0000, 16'h0100, 4'b0000, 1'b0};
      vecs[10] = '{ADDSP, 16'h00FF, 16'h0001, 4'b1100, 16'h0100, 4'b0011, 1'b0};
      vecs[11] = '{DEC16, 16'h1000, 16'hFFFF, 4'b0011, 16'h0FFF, 4'b0011, 1'b0};
      vecs[12] = '{ADD16, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = ADD16;
      A         = '0;
      B         = '0;
      flags_in  = '0;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("rst_in_ready", i, in_ready[i], 0);
         chk("rst_out_valid", i, out_valid[i], 0);
         chk("rst_res", i, res_v[i], 16'h0000);
         chk("rst_flags", i, fo_v[i], 4'b0000);
      end
      rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) chk("post_rst_in_ready", i, in_ready[i], 1);

      for (int n = 0; n < 12; n++) run_op(vecs[n], n);

      // Abort an ADD16 during the second slice cycle of the 4-bit instance.
      out_ready = 1'b1;
      op        = ADD16;
      A         = 16'h7777;
      B         = 16'h1111;
      flags_in  = 4'b0000;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) chk("midrst_in_ready", i, in_ready[i], 0);
      tick();
      rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("midrst_out_valid", i, out_valid[i], 0);
         chk("midrst_res", i, res_v[i], 16'h0000);
         chk("midrst_flags", i, fo_v[i], 4'b0000);
         chk("midrst_in_ready", i, in_ready[i], 1);
      end

      run_op(vecs[12], 12);
      chk("queue_empty", 0, exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
